// File: rtl/adder_rr_sched.sv
// Round-robin scheduler that time-shares one external 32-bit adder among NREQ requesters.
// Winner's operands are latched onto the adder, and the registered sum is returned over valid/ready.
module adder_rr_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [32*NREQ-1:0]   a_flat,
    input  logic [32*NREQ-1:0]   b_flat,
    output logic [NREQ-1:0]      gnt,
    output logic [31:0]          add_a,
    output logic [31:0]          add_b,
    input  logic [31:0]          add_s,
    input  logic                 add_co,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [31:0]          res_sum,
    output logic                 res_carry,
    output logic [IDW-1:0]       res_id,
    output logic                 busy,
    output logic [CNTW-1:0]      op_count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]      state;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  id_r;
    logic [IDW-1:0]  win;
    logic            found;
    logic [31:0]     sel_a;
    logic [31:0]     sel_b;
    logic [NREQ-1:0] win_onehot;

    // Search starts just past the last winner so every requester gets a turn.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        win   = ptr;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

    always_comb begin
        sel_a      = '0;
        sel_b      = '0;
        win_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == IDW'(i)) begin
                sel_a         = a_flat[32*i +: 32];
                sel_b         = b_flat[32*i +: 32];
                win_onehot[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= IDW'(NREQ - 1);
            id_r      <= '0;
            gnt       <= '0;
            add_a     <= '0;
            add_b     <= '0;
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_carry <= 1'b0;
            res_id    <= '0;
            op_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        add_a <= sel_a;
                        add_b <= sel_b;
                        gnt   <= win_onehot;
                        ptr   <= win;
                        id_r  <= win;
                        state <= CALC;
                    end
                end
                CALC: begin
                    res_sum   <= add_s;
                    res_carry <= add_co;
                    res_id    <= id_r;
                    res_valid <= 1'b1;
                    gnt       <= '0;
                    state     <= DONE;
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        op_count  <= op_count + CNTW'(1);
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_adder_rr_sched.sv
// Directed bench for adder_rr_sched: two instances (CNTW=16 and CNTW=4) share stimulus,
// each with its own behavioural adder.
module tb_adder_rr_sched;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    req = '0;
    logic [127:0]  a_flat;
    logic [127:0]  b_flat;
    logic          res_ready = 1'b1;

    logic [3:0]  gnt, gnt4;
    logic [31:0] add_a, add_b, add_s, add_a4, add_b4, add_s4;
    logic        add_co, add_co4;
    logic        res_valid, res_valid4, res_carry, res_carry4, busy, busy4;
    logic [31:0] res_sum, res_sum4;
    logic [1:0]  res_id, res_id4;
    logic [15:0] op_count;
    logic [3:0]  op_count4;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_gnt_cyc = 0;
    int ops = 0;

    logic [31:0] exp_sum [4];
    logic        exp_c   [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    assign {add_co, add_s}   = {1'b0, add_a} + {1'b0, add_b};
    assign {add_co4, add_s4} = {1'b0, add_a4} + {1'b0, add_b4};

    adder_rr_sched #(.NREQ(4), .IDW(2), .CNTW(16)) dut (
        .clk(clk), .rst(rst), .req(req), .a_flat(a_flat), .b_flat(b_flat),
        .gnt(gnt), .add_a(add_a), .add_b(add_b), .add_s(add_s), .add_co(add_co),
        .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
        .res_carry(res_carry), .res_id(res_id), .busy(busy), .op_count(op_count)
    );

    adder_rr_sched #(.NREQ(4), .IDW(2), .CNTW(4)) dut4 (
        .clk(clk), .rst(rst), .req(req), .a_flat(a_flat), .b_flat(b_flat),
        .gnt(gnt4), .add_a(add_a4), .add_b(add_b4), .add_s(add_s4), .add_co(add_co4),
        .res_valid(res_valid4), .res_ready(res_ready), .res_sum(res_sum4),
        .res_carry(res_carry4), .res_id(res_id4), .busy(busy4), .op_count(op_count4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered at a negedge with the FSM in IDLE; returns at a negedge back in IDLE.
    task automatic do_op(input logic [3:0] rq, input int win, input int stall, input bit gap_chk);
        req       = rq;
        res_ready = (stall == 0);
        @(negedge clk);
        chk("gnt", {60'd0, gnt}, 64'd1 << win);
        chk("busy_calc", {63'd0, busy}, 64'd1);
        if (gap_chk) chk("gnt_gap", 64'(cyc - last_gnt_cyc), 64'd3);
        last_gnt_cyc = cyc;
        req = '0;
        @(negedge clk);
        chk("valid", {63'd0, res_valid}, 64'd1);
        chk("sum", {32'd0, res_sum}, {32'd0, exp_sum[win]});
        chk("carry", {63'd0, res_carry}, {63'd0, exp_c[win]});
        chk("id", {62'd0, res_id}, 64'(win));
        chk("gnt_done", {60'd0, gnt}, 64'd0);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("stall_valid", {63'd0, res_valid}, 64'd1);
            chk("stall_sum", {32'd0, res_sum}, {32'd0, exp_sum[win]});
            chk("stall_id", {62'd0, res_id}, 64'(win));
            chk("stall_gnt", {60'd0, gnt}, 64'd0);
            chk("stall_busy", {63'd0, busy}, 64'd1);
            chk("stall_cnt", {48'd0, op_count}, 64'(ops));
        end
        res_ready = 1'b1;
        @(negedge clk);
        ops++;
        chk("valid_clr", {63'd0, res_valid}, 64'd0);
        chk("busy_idle", {63'd0, busy}, 64'd0);
        chk("op_count", {48'd0, op_count}, 64'(ops % 65536));
        chk("op_count4", {60'd0, op_count4}, 64'(ops % 16));
    endtask

    initial begin
        a_flat = {32'h1234_5678, 32'h8000_0000, 32'h0000_0001, 32'h0000_0010};
        b_flat = {32'h1111_1111, 32'h8000_0001, 32'hFFFF_FFFF, 32'h0000_0020};
        exp_sum[0] = 32'h0000_0030; exp_c[0] = 1'b0;
        exp_sum[1] = 32'h0000_0000; exp_c[1] = 1'b1;
        exp_sum[2] = 32'h0000_0001; exp_c[2] = 1'b1;
        exp_sum[3] = 32'h2345_6789; exp_c[3] = 1'b0;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_gnt", {60'd0, gnt}, 64'd0);
        chk("rst_valid", {63'd0, res_valid}, 64'd0);
        chk("rst_cnt", {48'd0, op_count}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_add_a", {32'd0, add_a}, 64'd0);
        chk("rst_sum", {32'd0, res_sum}, 64'd0);

        // Single request, carry out of bit 31.
        do_op(4'b0010, 1, 0, 1'b0);
        // ptr=1: req3 precedes req0 in the rotation.
        do_op(4'b1001, 3, 0, 1'b0);
        // ptr=3: full rotation 0,1,2,3,0 with back-to-back 3-cycle spacing.
        do_op(4'b1111, 0, 0, 1'b0);
        do_op(4'b1111, 1, 0, 1'b1);
        do_op(4'b1111, 2, 0, 1'b1);
        do_op(4'b1111, 3, 0, 1'b1);
        do_op(4'b1111, 0, 0, 1'b1);
        // Consumer backpressure for 5 cycles.
        do_op(4'b0100, 2, 5, 1'b0);

        // Reset in the middle of CALC aborts the op.
        req = 4'b0100;
        @(negedge clk);
        chk("pre_rst_gnt", {60'd0, gnt}, 64'b0100);
        req = '0;
        rst = 1'b1;
        #1;
        chk("arst_gnt", {60'd0, gnt}, 64'd0);
        chk("arst_valid", {63'd0, res_valid}, 64'd0);
        chk("arst_cnt", {48'd0, op_count}, 64'd0);
        chk("arst_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        ops = 0;
        @(negedge clk);
        chk("post_rst_valid", {63'd0, res_valid}, 64'd0);

        // 17 ops after reset: req0 first, then rotation; CNTW=4 wraps to 1.
        for (int j = 0; j < 17; j++) begin
            do_op(4'b1111, j % 4, 0, 1'b0);
        end
        chk("final_cnt16", {48'd0, op_count}, 64'd17);
        chk("final_cnt4", {60'd0, op_count4}, 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
